// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: takes one (a,b) bit pair per beat, MSB
// first. The first unequal pair decides the result. The result is published
// together with a one-cycle done pulse once WIDTH pairs have been accepted.
module serial_mag_comparator #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          bit_valid,
    input  logic          a_bit,
    input  logic          b_bit,
    output logic          bit_ready,
    output logic          busy,
    output logic          done,
    output logic          a_greater_b,
    output logic          a_equal_b,
    output logic          b_greater_a,
    output logic [CW-1:0] bit_count
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    typedef enum logic [1:0] {D_EQ, D_GT, D_LT} dec_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    dec_t          dec_q, dec_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bit_ready_q, bit_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          gt_q, gt_d;
    logic          eq_q, eq_d;
    logic          lt_q, lt_d;

    // Next-state, counter, running decision and registered-output computation
    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        case (state_q)
            S_IDLE: begin
                // bit_valid is deliberately ignored here, even alongside start
                if (start) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    dec_d   = D_EQ;
                end
            end
            S_SHIFT: begin
                if (bit_valid) begin
                    cnt_d = cnt_q + CW'(1);
                    // Once decided, the decision is frozen; later bits only count
                    if (dec_q == D_EQ) begin
                        if (a_bit && !b_bit) begin
                            dec_d = D_GT;
                        end else if (!a_bit && b_bit) begin
                            dec_d = D_LT;
                        end
                    end
                    if (cnt_q == LAST_IDX) begin
                        // Publish the final decision (including this last pair)
                        // on the same edge that enters DONE, so it lines up with done
                        state_d = S_DONE;
                        gt_d    = (dec_d == D_GT);
                        eq_d    = (dec_d == D_EQ);
                        lt_d    = (dec_d == D_LT);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        bit_ready_d = (state_d == S_SHIFT);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State and all outputs registered; async reset clears every result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dec_q       <= D_EQ;
            cnt_q       <= '0;
            bit_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            gt_q        <= 1'b0;
            eq_q        <= 1'b0;
            lt_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            dec_q       <= dec_d;
            cnt_q       <= cnt_d;
            bit_ready_q <= bit_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            gt_q        <= gt_d;
            eq_q        <= eq_d;
            lt_q        <= lt_d;
        end
    end

    assign bit_ready   = bit_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign a_greater_b = gt_q;
    assign a_equal_b   = eq_q;
    assign b_greater_a = lt_q;
    assign bit_count   = cnt_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench for serial_mag_comparator: the driver pushes the expected
// {gt,eq,lt} for each complete comparison; a monitor pops on every done.
module tb_serial_mag_comparator;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          bit_valid = 1'b0;
    logic          a_bit = 1'b0;
    logic          b_bit = 1'b0;
    logic          bit_ready;
    logic          busy;
    logic          done;
    logic          a_greater_b;
    logic          a_equal_b;
    logic          b_greater_a;
    logic [CW-1:0] bit_count;

    int vectors = 0;
    int miscompares = 0;
    logic [2:0] exp_q[$];

    serial_mag_comparator #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
        .a_bit(a_bit), .b_bit(b_bit), .bit_ready(bit_ready), .busy(busy),
        .done(done), .a_greater_b(a_greater_b), .a_equal_b(a_equal_b),
        .b_greater_a(b_greater_a), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer comparison of the whole operands
    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        return {a > b, a == b, a < b};
    endfunction

    // Monitor: pops an expectation on every done, checks holding otherwise
    initial begin
        logic [2:0] last;
        logic [2:0] exp;
        logic       prev_done;
        last = 3'b000;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_outputs",
                      {bit_ready, busy, done, a_greater_b, a_equal_b, b_greater_a},
                      0);
                check("reset_count", bit_count, 0);
                last = 3'b000;
                prev_done = 1'b0;
            end else if (done) begin
                check("done_single_cycle", prev_done, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp = exp_q.pop_front();
                    check("result", {a_greater_b, a_equal_b, b_greater_a}, exp);
                    last = exp;
                end
                check("done_count", bit_count, W);
                check("done_busy", busy, 1);
                check("done_ready", bit_ready, 0);
                prev_done = 1'b1;
            end else begin
                check("result_hold", {a_greater_b, a_equal_b, b_greater_a}, last);
                prev_done = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a comparison from IDLE; optionally present a bit pair alongside start
    task automatic start_cmp(input bit with_bit);
        check("idle_busy", busy, 0);
        check("idle_ready", bit_ready, 0);
        start = 1'b1;
        if (with_bit) begin
            bit_valid = 1'b1;
            a_bit = 1'b1;
            b_bit = 1'b0;
        end
        tick();
        start = 1'b0;
        bit_valid = 1'b0;
        check("start_busy", busy, 1);
        check("start_ready", bit_ready, 1);
        check("start_count", bit_count, 0);
    endtask

    // One full comparison with optional stall and start pulses in SHIFT/DONE
    task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int gap_after, input int gap_len,
                           input bit start_mid, input bit start_done, input bit with_bit);
        start_cmp(with_bit);
        for (int i = W - 1; i >= 0; i--) begin
            check("beat_ready", bit_ready, 1);
            if (start_mid && i == W - 4) start = 1'b1;
            if (i == 0) exp_q.push_back(model(a, b));
            bit_valid = 1'b1;
            a_bit = a[i];
            b_bit = b[i];
            tick();
            bit_valid = 1'b0;
            start = 1'b0;
            check("beat_count", bit_count, W - i);
            if (W - i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    tick();
                    check("stall_count", bit_count, gap_after);
                    check("stall_done", done, 0);
                end
            end
        end
        check("done_latency", done, 1);
        if (start_done) start = 1'b1;
        tick();
        start = 1'b0;
        check("after_done", done, 0);
        check("after_busy", busy, 0);
        check("hold_count", bit_count, W);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a, b;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Equal operands, back-to-back beats
        run_cmp(8'hA5, 8'hA5, 0, 0, 0, 0, 0);
        repeat (2) tick();
        // MSB decides GT
        run_cmp(8'h80, 8'h7F, 0, 0, 0, 0, 0);
        // LSB decides LT with a 3-cycle stall after beat 4
        run_cmp(8'h00, 8'h01, 4, 3, 0, 0, 0);
        // start pulsed in SHIFT and in DONE
        run_cmp(8'h5A, 8'h5B, 0, 0, 1, 1, 0);
        tick();
        check("idle_after_done_start", busy, 0);
        // start with bit_valid in IDLE: that pair must not count
        run_cmp(8'h00, 8'h00, 0, 0, 0, 0, 1);

        // Mid-comparison reset abort
        start_cmp(0);
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            a_bit = 1'b1;
            b_bit = 1'b0;
            tick();
        end
        bit_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_outputs",
              {bit_ready, busy, done, a_greater_b, a_equal_b, b_greater_a}, 0);
        check("abort_count", bit_count, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset_done", done, 0);
        run_cmp(8'h3C, 8'h3C, 0, 0, 0, 0, 0);

        // Back-to-back GT then LT
        run_cmp(8'hC3, 8'h43, 0, 0, 0, 0, 0);
        run_cmp(8'h10, 8'h11, 0, 0, 0, 0, 0);

        // Randomized comparisons
        for (int n = 0; n < 30; n++) begin
            a = W'($urandom);
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ (W'(1) << $urandom_range(0, W - 1));
                default: b = W'($urandom);
            endcase
            run_cmp(a, b, $urandom_range(1, W - 1), $urandom_range(0, 3),
                    $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
        end

        repeat (3) tick();
        check("scoreboard_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
